// File: rtl/gol_seed_editor_if.sv
// Bus between the seed editor and the board/CA-grid side: raw buttons in,
// seed bitmap, cursor and load strobe out.
interface gol_seed_editor_if #(
  parameter int GRID_H = 20,
  parameter int GRID_V = 20
);
  logic                       btn_up;
  logic                       btn_down;
  logic                       btn_left;
  logic                       btn_right;
  logic                       btn_toggle;
  logic                       btn_clear;
  logic                       btn_commit;
  logic [GRID_V*GRID_H-1:0]   seed_out;
  logic [$clog2(GRID_V)-1:0]  cursor_row;
  logic [$clog2(GRID_H)-1:0]  cursor_col;
  logic                       load_out;
  logic                       busy;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_toggle, btn_clear, btn_commit,
    input  seed_out, cursor_row, cursor_col, load_out, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_toggle, btn_clear, btn_commit,
    output seed_out, cursor_row, cursor_col, load_out, busy
  );
endinterface

// File: rtl/gol_seed_editor.sv
// Game of Life seed editor: debounced buttons move a wrapping cursor and edit a
// GRID_V x GRID_H seed bitmap; clear sweeps the bitmap one row per cycle and
// commit emits a LOAD_CYCLES-long load strobe to the CA grid.
// Build option: define SEED_PRESET_EN to reset the bitmap to a T-tetromino
// (needs GRID_V >= 8, GRID_H >= 9); otherwise the reset bitmap is all zeros.
module gol_seed_editor #(
  parameter int GRID_H          = 20,
  parameter int GRID_V          = 20,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LOAD_CYCLES     = 2
) (
  input  logic              clk,
  input  logic              rst,
  gol_seed_editor_if.slave  bus
);

  localparam int NCELL = GRID_V * GRID_H;
  localparam int RW    = $clog2(GRID_V);
  localparam int CWID  = $clog2(GRID_H);
  localparam int IW    = $clog2(NCELL);
  localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW    = $clog2(LOAD_CYCLES + 1);
  localparam int NBTN  = 7;

  localparam int B_UP     = 0;
  localparam int B_DOWN   = 1;
  localparam int B_LEFT   = 2;
  localparam int B_RIGHT  = 3;
  localparam int B_TOGGLE = 4;
  localparam int B_CLEAR  = 5;
  localparam int B_COMMIT = 6;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CLEAR  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  function automatic logic [NCELL-1:0] reset_pattern();
    logic [NCELL-1:0] p;
    p = '0;
`ifdef SEED_PRESET_EN
    p[7*GRID_H + 6] = 1'b1;
    p[7*GRID_H + 7] = 1'b1;
    p[7*GRID_H + 8] = 1'b1;
    p[6*GRID_H + 7] = 1'b1;
`endif
    return p;
  endfunction

  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] db_lvl;
  logic [NBTN-1:0] db_lvl_d;
  logic [NBTN-1:0] press;
  logic [DW-1:0]   db_cnt [NBTN];

  logic [1:0]       state;
  logic [RW-1:0]    row_cnt;
  logic [LW-1:0]    load_cnt;
  logic [NCELL-1:0] seed;
  logic [RW-1:0]    cur_row;
  logic [CWID-1:0]  cur_col;
  logic [RW-1:0]    row_nxt;
  logic [CWID-1:0]  col_nxt;
  logic [IW-1:0]    tog_idx;
  logic [IW-1:0]    clr_base;

  assign raw = {bus.btn_commit, bus.btn_clear, bus.btn_toggle, bus.btn_right,
                bus.btn_left, bus.btn_down, bus.btn_up};

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a sample differing from the accepted level must persist for
  // DEBOUNCE_CYCLES cycles; any return to the old level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_lvl   <= '0;
      db_lvl_d <= '0;
      for (int unsigned i = 0; i < NBTN; i++) db_cnt[i] <= '0;
    end else begin
      db_lvl_d <= db_lvl;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press = db_lvl & ~db_lvl_d;

  // Next cursor position with wrap-around; opposing moves cancel per axis.
  always_comb begin
    row_nxt = cur_row;
    col_nxt = cur_col;
    if (press[B_UP] && !press[B_DOWN])
      row_nxt = (cur_row == '0) ? RW'(GRID_V - 1) : cur_row - RW'(1);
    else if (press[B_DOWN] && !press[B_UP])
      row_nxt = (cur_row == RW'(GRID_V - 1)) ? '0 : cur_row + RW'(1);
    if (press[B_LEFT] && !press[B_RIGHT])
      col_nxt = (cur_col == '0) ? CWID'(GRID_H - 1) : cur_col - CWID'(1);
    else if (press[B_RIGHT] && !press[B_LEFT])
      col_nxt = (cur_col == CWID'(GRID_H - 1)) ? '0 : cur_col + CWID'(1);
    tog_idx  = IW'(int'(cur_row) * GRID_H + int'(cur_col));
    clr_base = IW'(int'(row_cnt) * GRID_H);
  end

  // Editor FSM: events are only honoured in IDLE (dropped, not queued, while busy).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      row_cnt  <= '0;
      load_cnt <= '0;
      seed     <= reset_pattern();
      cur_row  <= '0;
      cur_col  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press[B_CLEAR]) begin
            state   <= CLEAR;
            row_cnt <= '0;
          end else if (press[B_COMMIT]) begin
            state    <= COMMIT;
            load_cnt <= '0;
          end else if (press[B_TOGGLE]) begin
            seed[tog_idx] <= ~seed[tog_idx];
          end else begin
            cur_row <= row_nxt;
            cur_col <= col_nxt;
          end
        end
        CLEAR: begin
          seed[clr_base +: GRID_H] <= '0;
          if (row_cnt == RW'(GRID_V - 1)) begin
            state   <= IDLE;
            row_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + RW'(1);
          end
        end
        COMMIT: begin
          if (load_cnt == LW'(LOAD_CYCLES - 1)) begin
            state    <= IDLE;
            load_cnt <= '0;
          end else begin
            load_cnt <= load_cnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // load_out decodes straight from state so an asynchronous reset drops it at once.
  assign bus.seed_out   = seed;
  assign bus.cursor_row = cur_row;
  assign bus.cursor_col = cur_col;
  assign bus.load_out   = (state == COMMIT);
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_gol_seed_editor.sv
// Directed bench for gol_seed_editor (20x20, DEBOUNCE_CYCLES=4, LOAD_CYCLES=2).
module tb_gol_seed_editor;

  localparam int GH = 20;
  localparam int GV = 20;
  localparam int NC = GH * GV;

  localparam logic [6:0] UP  = 7'h01;
  localparam logic [6:0] DN  = 7'h02;
  localparam logic [6:0] LF  = 7'h04;
  localparam logic [6:0] RT  = 7'h08;
  localparam logic [6:0] TG  = 7'h10;
  localparam logic [6:0] CL  = 7'h20;
  localparam logic [6:0] CM  = 7'h40;

  typedef struct {
    logic [6:0] btn;
    int         row;
    int         col;
    int         bit_idx;
    logic       bit_val;
    int         pop;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  vec_t           tbl [22];
  logic [NC-1:0]  rst_pat;
  logic [NC-1:0]  pre;

  gol_seed_editor_if #(.GRID_H(GH), .GRID_V(GV)) bus ();

  gol_seed_editor #(
    .GRID_H(GH), .GRID_V(GV), .DEBOUNCE_CYCLES(4), .LOAD_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_seed(input string nm, input logic [NC-1:0] exp);
    n_vec++;
    if (bus.seed_out !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, bus.seed_out, exp);
    end
  endtask

  task automatic set_btns(input logic [6:0] m);
    bus.btn_up     = m[0];
    bus.btn_down   = m[1];
    bus.btn_left   = m[2];
    bus.btn_right  = m[3];
    bus.btn_toggle = m[4];
    bus.btn_clear  = m[5];
    bus.btn_commit = m[6];
  endtask

  task automatic press(input logic [6:0] m, input int hold, input int settle);
    set_btns(m);
    repeat (hold) @(negedge clk);
    set_btns(7'h00);
    repeat (settle) @(negedge clk);
  endtask

  task automatic wait_busy(input string nm);
    int t;
    t = 0;
    while (!bus.busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_busy_seen"}, 64'(bus.busy), 64'd1);
  endtask

  initial begin
    int bcnt, lcnt, frz;

    rst_pat = '0;
`ifdef SEED_PRESET_EN
    rst_pat[127] = 1'b1;
    rst_pat[146] = 1'b1;
    rst_pat[147] = 1'b1;
    rst_pat[148] = 1'b1;
`endif

    //           btn          row col bit val pop
    tbl[0]  = '{LF,            0, 19,   0, 1'b0, 0};
    tbl[1]  = '{UP,           19, 19,   0, 1'b0, 0};
    tbl[2]  = '{UP|DN,        19, 19,   0, 1'b0, 0};
    tbl[3]  = '{RT,           19,  0,   0, 1'b0, 0};
    tbl[4]  = '{DN,            0,  0,   0, 1'b0, 0};
    tbl[5]  = '{DN|RT,         1,  1,   0, 1'b0, 0};
    tbl[6]  = '{LF|RT|DN,      2,  1,   0, 1'b0, 0};
    tbl[7]  = '{DN|RT,         3,  2,   0, 1'b0, 0};
    tbl[8]  = '{DN|RT,         4,  3,   0, 1'b0, 0};
    tbl[9]  = '{DN|RT,         5,  4,   0, 1'b0, 0};
    tbl[10] = '{DN|RT,         6,  5,   0, 1'b0, 0};
    tbl[11] = '{DN|RT,         7,  6, 146, 1'b0, 0};
    tbl[12] = '{TG,            7,  6, 146, 1'b1, 1};
    tbl[13] = '{TG|UP,         7,  6, 146, 1'b0, 0};
    tbl[14] = '{TG,            7,  6, 146, 1'b1, 1};
    tbl[15] = '{UP|LF,         6,  5, 146, 1'b1, 1};
    tbl[16] = '{TG,            6,  5, 125, 1'b1, 2};
    tbl[17] = '{UP|DN|LF|RT,   6,  5, 125, 1'b1, 2};
    tbl[18] = '{TG|CM,         6,  5, 125, 1'b1, 2};
    tbl[19] = '{CL|TG,         6,  5, 125, 1'b0, 0};
    tbl[20] = '{TG,            6,  5, 125, 1'b1, 1};
    tbl[21] = '{TG|LF,         6,  5, 125, 1'b0, 0};

    // Reset state
    set_btns(7'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_seed("rst_seed", rst_pat);
    chk("rst_row", 64'(bus.cursor_row), 64'd0);
    chk("rst_col", 64'(bus.cursor_col), 64'd0);
    chk("rst_load", 64'(bus.load_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_seed("post_rst_seed", rst_pat);

    // Start the table from an empty bitmap in either build
    press(CL, 6, 30);
    chk_seed("init_clear", '0);

    for (int i = 0; i < 22; i++) begin
      press(tbl[i].btn, 6, 30);
      chk($sformatf("vec%0d_row", i), 64'(bus.cursor_row), 64'(tbl[i].row));
      chk($sformatf("vec%0d_col", i), 64'(bus.cursor_col), 64'(tbl[i].col));
      chk($sformatf("vec%0d_bit", i), 64'(bus.seed_out[tbl[i].bit_idx]), 64'(tbl[i].bit_val));
      chk($sformatf("vec%0d_pop", i), 64'($countones(bus.seed_out)), 64'(tbl[i].pop));
      chk($sformatf("vec%0d_busy", i), 64'({bus.busy, bus.load_out}), 64'd0);
    end

    // Debounce: 3-cycle glitch ignored, 10-cycle hold toggles exactly once
    press(TG, 3, 12);
    chk("glitch_bit", 64'(bus.seed_out[125]), 64'd0);
    press(TG, 10, 12);
    chk("hold_bit", 64'(bus.seed_out[125]), 64'd1);
    chk("hold_pop", 64'($countones(bus.seed_out)), 64'd1);

    // Commit: 2-cycle load pulse, seed frozen, toggle inside window dropped
    pre = bus.seed_out;
    set_btns(CM);
    @(negedge clk);
    set_btns(CM | TG);
    wait_busy("commit");
    bcnt = 0; lcnt = 0; frz = 0;
    while (bus.busy && bcnt < 100) begin
      bcnt++;
      if (bus.load_out) lcnt++;
      if (bus.seed_out !== pre) frz++;
      @(negedge clk);
    end
    chk("commit_busy_cycles", 64'(bcnt), 64'd2);
    chk("commit_load_cycles", 64'(lcnt), 64'd2);
    chk("commit_frozen", 64'(frz), 64'd0);
    chk("commit_load_after", 64'(bus.load_out), 64'd0);
    set_btns(7'h00);
    repeat (12) @(negedge clk);
    chk_seed("commit_toggle_dropped", pre);

    // Clear with bits set: exactly 20 busy cycles, bitmap zeroed, cursor kept
    press(DN|RT, 6, 12);
    press(TG, 6, 12);
    chk("pre_clear_pop", 64'($countones(bus.seed_out)), 64'd2);
    set_btns(CL);
    wait_busy("clear");
    bcnt = 0; lcnt = 0;
    while (bus.busy && bcnt < 100) begin
      bcnt++;
      if (bus.load_out) lcnt++;
      @(negedge clk);
    end
    chk("clear_busy_cycles", 64'(bcnt), 64'd20);
    chk("clear_no_load", 64'(lcnt), 64'd0);
    set_btns(7'h00);
    repeat (12) @(negedge clk);
    chk_seed("clear_seed", '0);
    chk("clear_row", 64'(bus.cursor_row), 64'd7);
    chk("clear_col", 64'(bus.cursor_col), 64'd6);

    // Reset at clear cycle 10
    press(TG, 6, 12);
    chk("pre_rst_bit", 64'(bus.seed_out[146]), 64'd1);
    set_btns(CL);
    wait_busy("rclear");
    repeat (9) @(negedge clk);
    chk("rclear_busy_c10", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_seed("rclear_seed", rst_pat);
    chk("rclear_row", 64'(bus.cursor_row), 64'd0);
    chk("rclear_col", 64'(bus.cursor_col), 64'd0);
    chk("rclear_busy", 64'(bus.busy), 64'd0);
    chk("rclear_load", 64'(bus.load_out), 64'd0);
    set_btns(7'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-commit drops load_out without a clock edge
    set_btns(CM);
    lcnt = 0;
    while (!bus.load_out && lcnt < 40) begin
      @(negedge clk);
      lcnt++;
    end
    chk("rcommit_load_seen", 64'(bus.load_out), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rcommit_load", 64'(bus.load_out), 64'd0);
    chk("rcommit_busy", 64'(bus.busy), 64'd0);
    set_btns(7'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
